// File: rtl/controller_repeat.sv
// controller_repeat: per-channel button front end. Each channel synchronizes
// its raw input, debounces it, emits a one-cycle press pulse, optionally
// auto-repeats while held, and drives an activity LED that stays lit for a
// fixed time after the channel's most recent pulse. A global block input
// mutes everything and forces a fresh release/press before new pulses.
//
// Per-channel FSM state lives in gen_ch[i].state_q so checkers can bind to it.
//
// Handshake: none. Outputs are free-running one-cycle pulses with no
// back-pressure; key_* are combinational decodes of the registered pulses.
module controller_repeat #(
  parameter int N_BUTTONS           = 12,
  parameter int DEBOUNCE_CYCLES     = 50_000,
  parameter int LED_CYCLES          = 50_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         block_controller,
  input  logic [N_BUTTONS-1:0]         repeat_enable,
  input  logic [N_BUTTONS-1:0]         controller_input,
  output logic [N_BUTTONS-1:0]         controller_output,
  output logic [N_BUTTONS-1:0]         LEDR,
  output logic                         key_valid,
  output logic [$clog2(N_BUTTONS)-1:0] key_code,
  output logic                         key_multi
);

  localparam int KW   = $clog2(N_BUTTONS);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int LW   = (LED_CYCLES < 1) ? 1 : $clog2(LED_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    HELD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic [N_BUTTONS-1:0] sync1_q;
  logic [N_BUTTONS-1:0] sync2_q;
  logic [N_BUTTONS-1:0] pulse_vec;

  // Two-flop synchronizer; keeps running while blocked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= controller_input;
      sync2_q <= sync1_q;
    end
  end

  // Register the pulses so downstream sees clean one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!reset) controller_output <= '0;
    else        controller_output <= pulse_vec;
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : gen_ch
    state_t          state_q, state_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            rep_q, rep_d;
    logic            pulse_d;
    logic [LW-1:0]   led_q;
    logic            ledr_q;
    int              hold_tgt;

    assign pulse_vec[i] = pulse_d;
    assign LEDR[i]      = ledr_q;

    // State and counter registers.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= IDLE;
        deb_q   <= '0;
        hold_q  <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
      end
    end

    // Next state: debounce, first pulse, then delay/rate auto-repeat.
    // rep_q selects the rate interval once the first repeat has fired.
    always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      hold_d   = hold_q;
      rep_d    = rep_q;
      pulse_d  = 1'b0;
      hold_tgt = rep_q ? REPEAT_RATE_CYCLES : REPEAT_DELAY_CYCLES;
      if (block_controller) begin
        state_d = sync2_q[i] ? WAIT_RELEASE : IDLE;
        deb_d   = '0;
        hold_d  = '0;
        rep_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sync2_q[i]) begin
              state_d = DEBOUNCE;
              deb_d   = DW'(1);
            end
          end
          DEBOUNCE: begin
            if (!sync2_q[i]) begin
              state_d = IDLE;
              deb_d   = '0;
            end else if (int'(deb_q) + 1 >= DEBOUNCE_CYCLES) begin
              // The current sample completes the required high run.
              state_d = HELD;
              pulse_d = 1'b1;
              deb_d   = '0;
              hold_d  = '0;
              rep_d   = 1'b0;
            end else begin
              deb_d = deb_q + DW'(1);
            end
          end
          HELD: begin
            if (!sync2_q[i]) begin
              state_d = IDLE;
              hold_d  = '0;
              rep_d   = 1'b0;
            end else if (!repeat_enable[i]) begin
              hold_d = '0;
              rep_d  = 1'b0;
            end else if (int'(hold_q) + 1 >= hold_tgt && !controller_output[i]) begin
              // Never pulse on back-to-back cycles, even for tiny intervals.
              pulse_d = 1'b1;
              hold_d  = '0;
              rep_d   = 1'b1;
            end else if (int'(hold_q) < HMAX) begin
              hold_d = hold_q + HW'(1);
            end
          end
          WAIT_RELEASE: begin
            if (!sync2_q[i]) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // LED timer: reload on each pulse, lit until the count runs out.
    always_ff @(posedge clk) begin
      if (!reset || block_controller) begin
        led_q  <= '0;
        ledr_q <= 1'b0;
      end else if (controller_output[i]) begin
        led_q  <= LW'(LED_CYCLES);
        ledr_q <= (LED_CYCLES > 0);
      end else if (led_q != '0) begin
        led_q  <= led_q - LW'(1);
        ledr_q <= (led_q > LW'(1));
      end else begin
        ledr_q <= 1'b0;
      end
    end
  end

  // Decode of the registered pulse vector; lowest set index wins.
  always_comb begin
    key_valid = |controller_output;
    key_multi = (controller_output & (controller_output - 1'b1)) != '0;
    key_code  = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (controller_output[i]) key_code = KW'(i);
    end
  end

endmodule

// File: tb/tb_controller_repeat.sv
// Directed bench for controller_repeat with small timing parameters.
// Edge numbering: inputs are set before a rising edge ("edge e"), and
// outputs are sampled 1 time unit after that edge.
module tb_controller_repeat;

  logic       clk;
  logic       reset;
  logic       block_controller;
  logic [3:0] repeat_enable;
  logic [3:0] controller_input;
  logic [3:0] controller_output;
  logic [3:0] LEDR;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_multi;

  int tests_run;
  int tests_failed;

  controller_repeat #(
    .N_BUTTONS           (4),
    .DEBOUNCE_CYCLES     (4),
    .LED_CYCLES          (10),
    .REPEAT_DELAY_CYCLES (8),
    .REPEAT_RATE_CYCLES  (3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .block_controller  (block_controller),
    .repeat_enable     (repeat_enable),
    .controller_input  (controller_input),
    .controller_output (controller_output),
    .LEDR              (LEDR),
    .key_valid         (key_valid),
    .key_code          (key_code),
    .key_multi         (key_multi)
  );

  // Clock and initial drive values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    block_controller = 1'b0;
    repeat_enable    = 4'b0000;
    controller_input = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    tick();
    tests_run++;
    if (controller_output !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_out: got %b expected 0000", controller_output);
    end
    tests_run++;
    if (LEDR !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ledr: got %b expected 0000", LEDR);
    end
    tests_run++;
    if ({key_valid, key_code, key_multi} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_key: got valid=%b code=%0d multi=%b expected 0/0/0",
               key_valid, key_code, key_multi);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_out, exp_led;
    int pulses;
    do_reset();
    pulses = 0;
    controller_input = 4'b0100;
    for (int e = 0; e < 26; e++) begin
      if (e == 20) controller_input = 4'b0000;
      tick();
      exp_out = (e == 5) ? 4'b0100 : 4'b0000;
      exp_led = (e >= 6 && e <= 15) ? 4'b0100 : 4'b0000;
      if (controller_output != 4'b0000) pulses++;
      tests_run++;
      if (controller_output !== exp_out) begin
        tests_failed++;
        $display("FAIL clean_out e=%0d: got %b expected %b", e, controller_output, exp_out);
      end
      tests_run++;
      if (LEDR !== exp_led) begin
        tests_failed++;
        $display("FAIL clean_led e=%0d: got %b expected %b", e, LEDR, exp_led);
      end
      tests_run++;
      if (key_valid !== (e == 5)) begin
        tests_failed++;
        $display("FAIL clean_valid e=%0d: got %b", e, key_valid);
      end
      if (e == 5) begin
        tests_run++;
        if (key_code !== 2'd2 || key_multi !== 1'b0) begin
          tests_failed++;
          $display("FAIL clean_code: got code=%0d multi=%b expected 2/0", key_code, key_multi);
        end
      end
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL clean_count: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [0:19];
    do_reset();
    for (int e = 0; e < 20; e++) begin
      controller_input = ((e <= 2) || (e >= 4 && e <= 6)) ? 4'b0010 : 4'b0000;
      tick();
      tests_run++;
      if (controller_output !== 4'b0000 || LEDR !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bounce e=%0d: got out=%b led=%b expected 0000/0000",
                 e, controller_output, LEDR);
      end
    end
  endtask

  task automatic test_auto_repeat();
    int pl [8] = '{5, 13, 16, 19, 22, 25, 28, 31};
    logic exp_p, exp_l;
    do_reset();
    repeat_enable    = 4'b0010;
    controller_input = 4'b0010;
    for (int e = 0; e < 50; e++) begin
      if (e == 30) controller_input = 4'b0000;
      tick();
      exp_p = 1'b0;
      for (int k = 0; k < 8; k++) if (pl[k] == e) exp_p = 1'b1;
      exp_l = (e >= 6 && e <= 41);
      tests_run++;
      if (controller_output !== {2'b00, exp_p, 1'b0}) begin
        tests_failed++;
        $display("FAIL repeat_out e=%0d: got %b expected %b", e, controller_output,
                 {2'b00, exp_p, 1'b0});
      end
      tests_run++;
      if (LEDR !== {2'b00, exp_l, 1'b0}) begin
        tests_failed++;
        $display("FAIL repeat_led e=%0d: got %b expected %b", e, LEDR, {2'b00, exp_l, 1'b0});
      end
    end
  endtask

  task automatic test_repeat_disable();
    logic [3:0] exp_out;
    do_reset();
    repeat_enable    = 4'b1000;
    controller_input = 4'b1000;
    for (int e = 0; e < 30; e++) begin
      if (e == 10) repeat_enable = 4'b0000;
      if (e == 25) controller_input = 4'b0000;
      tick();
      exp_out = (e == 5) ? 4'b1000 : 4'b0000;
      tests_run++;
      if (controller_output !== exp_out) begin
        tests_failed++;
        $display("FAIL rep_disable e=%0d: got %b expected %b", e, controller_output, exp_out);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_out;
    do_reset();
    controller_input = 4'b1001;
    for (int e = 0; e < 12; e++) begin
      if (e == 10) controller_input = 4'b0000;
      tick();
      exp_out = (e == 5) ? 4'b1001 : 4'b0000;
      tests_run++;
      if (controller_output !== exp_out) begin
        tests_failed++;
        $display("FAIL simul_out e=%0d: got %b expected %b", e, controller_output, exp_out);
      end
      tests_run++;
      if (key_multi !== (e == 5) || key_valid !== (e == 5)) begin
        tests_failed++;
        $display("FAIL simul_flags e=%0d: got multi=%b valid=%b", e, key_multi, key_valid);
      end
      if (e == 5) begin
        tests_run++;
        if (key_code !== 2'd0) begin
          tests_failed++;
          $display("FAIL simul_code: got %0d expected 0", key_code);
        end
      end
    end
  endtask

  task automatic test_block();
    logic [3:0] exp_out, exp_led;
    do_reset();
    controller_input = 4'b0100;
    for (int e = 0; e < 45; e++) begin
      block_controller = (e >= 3 && e <= 12);
      if (e == 20) controller_input = 4'b0000;
      if (e == 26) controller_input = 4'b0100;
      if (e == 40) controller_input = 4'b0000;
      tick();
      exp_out = (e == 31) ? 4'b0100 : 4'b0000;
      exp_led = (e >= 32 && e <= 41) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (controller_output !== exp_out) begin
        tests_failed++;
        $display("FAIL block_out e=%0d: got %b expected %b", e, controller_output, exp_out);
      end
      tests_run++;
      if (LEDR !== exp_led) begin
        tests_failed++;
        $display("FAIL block_led e=%0d: got %b expected %b", e, LEDR, exp_led);
      end
    end
    block_controller = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] exp_out, exp_led;
    do_reset();
    repeat_enable    = 4'b0001;
    controller_input = 4'b0001;
    for (int e = 0; e < 33; e++) begin
      if (e == 14) begin
        reset            = 1'b0;
        controller_input = 4'b0000;
      end
      if (e == 15) reset = 1'b1;
      if (e == 25) controller_input = 4'b0001;
      tick();
      exp_out = (e == 5 || e == 13 || e == 30) ? 4'b0001 : 4'b0000;
      exp_led = ((e >= 6 && e <= 13) || e >= 31) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (controller_output !== exp_out) begin
        tests_failed++;
        $display("FAIL rstmid_out e=%0d: got %b expected %b", e, controller_output, exp_out);
      end
      tests_run++;
      if (LEDR !== exp_led) begin
        tests_failed++;
        $display("FAIL rstmid_led e=%0d: got %b expected %b", e, LEDR, exp_led);
      end
      if (e == 14) begin
        tests_run++;
        if ({key_valid, key_code, key_multi} !== 4'b0000) begin
          tests_failed++;
          $display("FAIL rstmid_key: got valid=%b code=%0d multi=%b expected 0/0/0",
                   key_valid, key_code, key_multi);
        end
      end
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b0;
    block_controller = 1'b0;
    repeat_enable    = 4'b0000;
    controller_input = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_disable();
    test_simultaneous();
    test_block();
    test_reset_mid_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
